mii_rx_deframer: RTL and testbench
==================================

Name: mii_rx_deframer

Overview:
- MII receive-side deframer, the counterpart of the MII transmit path in MBO_53_top.
- Samples 4-bit MII receive nibbles, strips preamble and SFD, and assembles bytes.
- Checks FCS (CRC-32), length and error conditions, and presents a byte stream with start/end markers and per-frame status to the ethernet_top packet logic.
- Runs entirely in the MII receive clock domain; the PHY rx clock drives clk.

Parameters:
- MIN_FRAME_BYTES, 64: minimum legal length in bytes, FCS included.
- MAX_FRAME_BYTES, 1518: maximum legal length in bytes, FCS included.
- CHECK_FCS, 1: 1 enables the CRC-32 check; 0 forces status[0] to 0.

Ports:
- clk  input  1  MII receive clock (PHY e_rx_clk)
- rst  input  1  asynchronous, active-high reset
- rx_d  input  4  MII receive nibble (e_rx_d), low nibble of each byte first
- rx_dv  input  1  receive data valid (e_rx_dv)
- rx_er  input  1  receive error (e_rx_er)
- out_data  output  8  received byte, FCS bytes included
- out_valid  output  1  out_data valid, single-cycle pulse
- out_sof  output  1  first byte of frame, qualified by out_valid
- out_eof  output  1  last byte of frame, qualified by out_valid
- out_status  output  4  valid with out_eof: [0] FCS bad, [1] rx_er seen, [2] odd nibble count, [3] length error
- frame_len  output  11  byte count including FCS, valid with out_eof
- frames_ok  output  16  count of frames with status 0, saturating
- frames_bad  output  16  count of frames with nonzero status or runt-in-SFD, saturating

Behaviour:
- Reset: all outputs 0, counters 0, FSM in IDLE, byte hold register empty.
- Clocking: all inputs registered once before use.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv=1 and rx_d=0x5 -> PREAMBLE.
  - rx_dv=1 with any other nibble -> DROP.
- PREAMBLE:
  - rx_d=0x5 -> stay.
  - rx_d=0xD (SFD) -> DATA; clear CRC, length, nibble phase and status.
  - Any other nibble -> DROP.
  - rx_dv=0 -> IDLE; no output, no counter change.
- DATA: nibble phase toggles each cycle. Phase 0 latches the low nibble; phase 1 completes the byte {rx_d, low}.
- Byte hold (needed to flag eof on the last byte):
  - A completed byte enters the hold register.
  - The previously held byte, if any, is emitted on out_data with out_valid=1 on the next cycle.
  - out_sof=1 on the first emitted byte of the frame.
  - Latency: byte N appears 2 cycles after byte N+1's high nibble is sampled at the pins, or 2 cycles after rx_dv falls for the last byte.
- End of frame (rx_dv falls in DATA):
  - Held byte is emitted with out_eof=1, out_status and frame_len.
  - status[2] is set if the phase is odd (the dribble nibble is discarded).
  - status[3] is set if frame_len < MIN_FRAME_BYTES.
  - status[0] is set if the CRC residue != 0xC704DD7B.
  - Exactly one of frames_ok / frames_bad increments.
- Zero-byte frame (rx_dv falls right after SFD): nothing is emitted; frames_bad increments.
- One-byte frame: a single byte is emitted with out_sof=1 and out_eof=1.
- rx_er=1 while rx_dv=1 in DATA: sets sticky status[1]; reception continues.
- Length overflow: when byte MAX_FRAME_BYTES+1 completes, the held byte is emitted with eof and status[3]=1, frame_len=MAX_FRAME_BYTES, then -> DROP.
- DROP: no output until rx_dv=0, then -> IDLE.
- Back-to-back frames: an IDLE cycle between frames is sufficient; the eof emission coincides with the first IDLE cycle of the next frame without loss.
- Counters saturate at 0xFFFF.
- Reset mid-frame: outputs clear immediately. If rx_dv=1 at reset release, the FSM goes to DROP so it never syncs mid-frame.
- CRC:
  - Reflected CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - Updated per nibble, LSB first, over all data nibbles including FCS.
  - Residue is compared after the last full byte.

Decomposition:
- Package mii_pkg holds:
  - state enum rx_state_t;
  - constants PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hC704DD7B, CRC_POLY_REFL=32'hEDB88320;
  - status bit index constants.
- One sub-module crc32_nibble: combinational next-CRC from the current CRC and a 4-bit input. It is reusable by the future transmit FCS generator.

Test Plan:
1. 7 bytes 0x55, SFD 0xD5, 60 bytes 0x00..0x3B, correct FCS from the bench model -> 64 bytes out; first byte 0x00 with sof, last FCS byte with eof; status 0, frame_len 64, frames_ok=1.
2. Same frame with byte 10 corrupted -> 64 bytes out, status=4'b0001, frames_bad=1.
3. Frame with an extra trailing nibble, plus rx_er pulsed mid-frame -> status bits [2] and [1] set, frame_len 64.
4. 1600-byte frame with MAX=1518 -> exactly 1518 bytes out, eof on byte 1518, status[3]=1; the following good 64-byte frame is received correctly.
5. rx_dv=1 during reset release mid-frame, then a good frame after an idle gap -> no output for the partial frame; the next frame is ok, frames_ok=1.
6. Preamble followed by nibble 0x7 instead of SFD, then an SFD-only frame (rx_dv falls after 0xD) -> no bytes emitted; frames_bad increments only for the SFD-only frame.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  // out_status bit positions
  localparam int STS_FCS  = 0;
  localparam int STS_RXER = 1;
  localparam int STS_ODD  = 2;
  localparam int STS_LEN  = 3;

  // The CRC register is kept in reflected (LSB-first) form; the magic
  // residue is quoted MSB-first, so the register is bit-reversed to compare.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_nibble.sv
// Combinational reflected CRC-32 update over one nibble, bit 0 first.
// Latency: combinational.
// Backpressure: none.
// Ports: crc_in  current CRC register
//        nib     4-bit input, nib[0] processed first
//        crc_out CRC register after the nibble
module crc32_nibble
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) begin
        c = (c >> 1) ^ CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles bytes, checks FCS/length/errors.
// Latency: a byte is emitted when the next byte completes, or when rx_dv drops for the last byte.
// Backpressure: none; the PHY cannot be stalled, output is a one-cycle valid pulse per byte.
// Ports: clk/rst          PHY rx clock, async active-high reset
//        rx_d/rx_dv/rx_er raw MII receive pins (registered once on entry)
//        out_*            byte stream with sof/eof markers, status and length at eof
//        frames_ok/bad    saturating frame counters
module mii_rx_deframer
  import mii_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int CHECK_FCS       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rx_d,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [3:0]  out_status,
  output logic [10:0] frame_len,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

  // Input sampling
  logic [3:0] rx_d_q;
  logic       rx_dv_q;
  logic       rx_er_q;
  logic       in_valid;   // input registers hold real pin samples (not reset values)
  logic       armed;      // an rx_dv=0 sample has been seen since reset

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d_q   <= '0;
      rx_dv_q  <= 1'b0;
      rx_er_q  <= 1'b0;
      in_valid <= 1'b0;
      armed    <= 1'b0;
    end else begin
      rx_d_q   <= rx_d;
      rx_dv_q  <= rx_dv;
      rx_er_q  <= rx_er;
      in_valid <= 1'b1;
      // Only arm once a genuine inter-frame gap is observed, so a reset
      // released mid-frame cannot lock onto payload that looks like preamble.
      if (in_valid && !rx_dv_q) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM
  rx_state_t state_q, state_d;
  logic      start_frame;
  logic      take_low;
  logic      take_byte;
  logic      end_frame;
  logic      overflow;

  logic        phase;
  logic [3:0]  low_nib;
  logic [31:0] crc;
  logic [31:0] crc_byte;  // CRC as of the last complete byte (excludes a dribble nibble)
  logic [31:0] crc_next;
  logic [10:0] len;
  logic [7:0]  hold;
  logic        hold_vld;
  logic        first_pend;
  logic        er_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    take_low    = 1'b0;
    take_byte   = 1'b0;
    end_frame   = 1'b0;
    overflow    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && rx_dv_q) begin
          if (armed && rx_d_q == PREAMBLE_NIB) begin
            state_d = ST_PREAMBLE;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv_q) begin
          state_d = ST_IDLE;
        end else if (rx_d_q == PREAMBLE_NIB) begin
          state_d = ST_PREAMBLE;
        end else if (rx_d_q == SFD_NIB) begin
          state_d     = ST_DATA;
          start_frame = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!rx_dv_q) begin
          state_d   = ST_IDLE;
          end_frame = 1'b1;
        end else if (!phase) begin
          take_low = 1'b1;
        end else if (len == MAX_LEN) begin
          // This byte would be MAX+1: close the frame on the held byte.
          state_d  = ST_DROP;
          overflow = 1'b1;
        end else begin
          take_byte = 1'b1;
        end
      end
      ST_DROP: begin
        if (!rx_dv_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  crc32_nibble u_crc (
    .crc_in  (crc),
    .nib     (rx_d_q),
    .crc_out (crc_next)
  );

  // Status reported with the eof byte
  logic [3:0] eof_status;
  logic       frame_done;
  logic       frame_bad;

  always_comb begin
    eof_status = '0;
    if (overflow) begin
      eof_status[STS_LEN]  = 1'b1;
      eof_status[STS_RXER] = er_seen | rx_er_q;
    end else begin
      eof_status[STS_FCS]  = (CHECK_FCS != 0) && (bitrev32(crc_byte) != CRC_RESIDUE);
      eof_status[STS_RXER] = er_seen;
      eof_status[STS_ODD]  = phase;
      eof_status[STS_LEN]  = (len < MIN_LEN);
    end
  end

  assign frame_done = end_frame | overflow;
  // A frame that ends before any byte completed has nothing to emit but is still bad.
  assign frame_bad  = (eof_status != 4'd0) || !hold_vld;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_status <= '0;
      frame_len  <= '0;
      frames_ok  <= '0;
      frames_bad <= '0;
      phase      <= 1'b0;
      low_nib    <= '0;
      crc        <= CRC_INIT;
      crc_byte   <= CRC_INIT;
      len        <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      first_pend <= 1'b0;
      er_seen    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_status <= '0;
      frame_len  <= '0;

      if (state_q == ST_DATA && rx_dv_q) begin
        crc   <= crc_next;
        phase <= ~phase;
        if (rx_er_q) begin
          er_seen <= 1'b1;
        end
      end

      if (take_low) begin
        low_nib <= rx_d_q;
      end

      if (take_byte) begin
        if (hold_vld) begin
          out_valid  <= 1'b1;
          out_data   <= hold;
          out_sof    <= first_pend;
          first_pend <= 1'b0;
        end
        hold     <= {rx_d_q, low_nib};
        hold_vld <= 1'b1;
        len      <= len + 11'd1;
        crc_byte <= crc_next;
      end

      if (frame_done) begin
        hold_vld <= 1'b0;
        if (hold_vld) begin
          out_valid  <= 1'b1;
          out_data   <= hold;
          out_sof    <= first_pend;
          out_eof    <= 1'b1;
          out_status <= eof_status;
          frame_len  <= len;
          first_pend <= 1'b0;
        end
        if (frame_bad) begin
          if (frames_bad != 16'hFFFF) begin
            frames_bad <= frames_bad + 16'd1;
          end
        end else begin
          if (frames_ok != 16'hFFFF) begin
            frames_ok <= frames_ok + 16'd1;
          end
        end
      end

      if (start_frame) begin
        crc        <= CRC_INIT;
        crc_byte   <= CRC_INIT;
        len        <= '0;
        phase      <= 1'b0;
        er_seen    <= 1'b0;
        first_pend <= 1'b1;
        hold_vld   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed bench for mii_rx_deframer: drives MII nibbles, collects the byte stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_mii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rx_d;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [3:0]  out_status;
  logic [10:0] frame_len;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  mii_rx_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .rx_d       (rx_d),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_status (out_status),
    .frame_len  (frame_len),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int          sof_cnt;
  int          sof_idx;
  int          eof_cnt;
  int          eof_idx;
  logic [3:0]  last_status;
  logic [10:0] last_len;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (out_valid) begin
      if (out_sof) begin
        sof_cnt++;
        sof_idx = rx_q.size();
      end
      if (out_eof) begin
        eof_cnt++;
        eof_idx     = rx_q.size();
        last_status = out_status;
        last_len    = frame_len;
      end
      rx_q.push_back(out_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    sof_cnt     = 0;
    sof_idx     = -1;
    eof_cnt     = 0;
    eof_idx     = -1;
    last_status = 4'hF;
    last_len    = 11'h7FF;
  endtask

  task automatic nib(input logic [3:0] d, input logic dv, input logic er);
    @(negedge clk);
    rx_d  = d;
    rx_dv = dv;
    rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[3:0], 1'b1, 1'b0);
    nib(b[7:4], 1'b1, 1'b0);
  endtask

  task automatic send_preamble();
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  // Payload 0,1,2,... then FCS computed bitwise, LSB first, FCS sent low byte first.
  task automatic build(input int n, input bit with_fcs);
    logic [31:0] r;
    logic [7:0]  b;
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'(i));
    if (with_fcs) begin
      r = 32'hFFFFFFFF;
      foreach (tx_q[i]) begin
        b = tx_q[i];
        for (int k = 0; k < 8; k++) begin
          if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
          else             r = r >> 1;
        end
      end
      r = ~r;
      tx_q.push_back(r[7:0]);
      tx_q.push_back(r[15:8]);
      tx_q.push_back(r[23:16]);
      tx_q.push_back(r[31:24]);
    end
  endtask

  // er_at: data nibble index on which rx_er is pulsed (-1 for none)
  task automatic send_frame(input bit extra_nib, input int er_at);
    send_preamble();
    foreach (tx_q[i]) begin
      nib(tx_q[i][3:0], 1'b1, (2*i == er_at));
      nib(tx_q[i][7:4], 1'b1, (2*i+1 == er_at));
    end
    if (extra_nib) nib(4'hA, 1'b1, 1'b0);
    idle(6);
  endtask

  task automatic check_bytes(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++) begin
      if (rx_q[i] !== tx_q[i]) mism++;
    end
    check(tag, mism, 0);
  endtask

  initial begin
    rst   = 1'b1;
    rx_d  = 4'h0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    clear_rx();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_status", out_status, 0);
    check("rst frame_len", frame_len, 0);
    check("rst frames_ok", frames_ok, 0);
    check("rst frames_bad", frames_bad, 0);
    rst = 1'b0;
    idle(4);

    // 1: good 64-byte frame
    clear_rx();
    build(60, 1'b1);
    send_frame(1'b0, -1);
    check("t1 count", rx_q.size(), 64);
    check("t1 first", rx_q.size() > 0 ? rx_q[0] : 8'hXX, 8'h00);
    check("t1 sof idx", sof_idx, 0);
    check("t1 sof cnt", sof_cnt, 1);
    check("t1 eof idx", eof_idx, 63);
    check("t1 status", last_status, 4'b0000);
    check("t1 len", last_len, 64);
    check("t1 ok", frames_ok, 1);
    check("t1 bad", frames_bad, 0);
    check_bytes("t1 data");

    // 2: byte 10 corrupted after the FCS is computed
    clear_rx();
    build(60, 1'b1);
    tx_q[10] = tx_q[10] ^ 8'h01;
    send_frame(1'b0, -1);
    check("t2 count", rx_q.size(), 64);
    check("t2 status", last_status, 4'b0001);
    check("t2 ok", frames_ok, 1);
    check("t2 bad", frames_bad, 1);
    check_bytes("t2 data");

    // 3: dribble nibble plus rx_er mid-frame
    clear_rx();
    build(60, 1'b1);
    send_frame(1'b1, 41);
    check("t3 count", rx_q.size(), 64);
    check("t3 status", last_status, 4'b0110);
    check("t3 len", last_len, 64);
    check("t3 bad", frames_bad, 2);
    check_bytes("t3 data");

    // 4: oversize frame truncated at MAX, then a good frame
    clear_rx();
    build(1600, 1'b0);
    send_frame(1'b0, -1);
    check("t4 count", rx_q.size(), 1518);
    check("t4 eof cnt", eof_cnt, 1);
    check("t4 eof idx", eof_idx, 1517);
    check("t4 len err", last_status[3], 1);
    check("t4 len", last_len, 1518);
    check("t4 bad", frames_bad, 3);
    check_bytes("t4 data");
    clear_rx();
    build(60, 1'b1);
    send_frame(1'b0, -1);
    check("t4b count", rx_q.size(), 64);
    check("t4b status", last_status, 4'b0000);
    check("t4b ok", frames_ok, 2);

    // 5: reset asserted and released while rx_dv is high
    send_preamble();
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h55);
    check("t5 rst valid", out_valid, 0);
    check("t5 rst ok", frames_ok, 0);
    check("t5 rst bad", frames_bad, 0);
    rst = 1'b0;
    clear_rx();
    // Payload that mimics preamble+SFD; must not be framed.
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    idle(6);
    check("t5 partial count", rx_q.size(), 0);
    check("t5 partial bad", frames_bad, 0);
    build(60, 1'b1);
    send_frame(1'b0, -1);
    check("t5 count", rx_q.size(), 64);
    check("t5 status", last_status, 4'b0000);
    check("t5 ok", frames_ok, 1);
    check_bytes("t5 data");

    // 6: broken preamble, then SFD-only frame
    clear_rx();
    repeat (8) nib(4'h5, 1'b1, 1'b0);
    nib(4'h7, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'hD5);
    idle(6);
    check("t6 bad preamble cnt", frames_bad, 0);
    send_preamble();
    idle(6);
    check("t6 count", rx_q.size(), 0);
    check("t6 bad", frames_bad, 1);
    check("t6 ok", frames_ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
